// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared constants and types for the matrix multiplier neighbourhood:
// default dimensions, C element width derivation, serializer state encoding
// and the drop-counter saturation value.
// No ports (package).
// Optional feature macro used by importers: MATRIX_SERIALIZER_COORD_EN.
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int DEF_DATA_WIDTH       = 8;
  localparam int DEF_A_ROWS           = 8;
  localparam int DEF_B_COLUMNS        = 5;
  localparam int DEF_A_COLUMNS_B_ROWS = 4;

  // Each C element is a sum of 'inner' products of two DATA_WIDTH operands.
  function automatic int c_data_width(input int dw, input int inner);
    return (2 * dw) + $clog2(inner);
  endfunction

  localparam int DEF_C_DATA_WIDTH = c_data_width(DEF_DATA_WIDTH, DEF_A_COLUMNS_B_ROWS);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_e;

  localparam logic [7:0] DROP_MAX = 8'd255;

endpackage

// File: rtl/matrix_result_serializer_if.sv
// -----------------------------------------------------------------------------
// matrix_result_serializer_if
// Valid/ready element stream from the serializer toward a narrow consumer.
// Signals:
//   m_valid    : element valid (master -> slave)
//   m_ready    : consumer ready (slave -> master)
//   m_data     : current element, C_DATA_WIDTH bits
//   m_last     : final element of a matrix
//   m_row/m_col/m_row_last : element coordinates, only with
//                            MATRIX_SERIALIZER_COORD_EN defined
// -----------------------------------------------------------------------------
interface matrix_result_serializer_if
  import matrix_pkg::*;
#(
  parameter int C_DATA_WIDTH = DEF_C_DATA_WIDTH
);
  logic                    m_valid;
  logic                    m_ready;
  logic [C_DATA_WIDTH-1:0] m_data;
  logic                    m_last;
`ifdef MATRIX_SERIALIZER_COORD_EN
  logic [$clog2(DEF_A_ROWS)-1:0]    m_row;
  logic [$clog2(DEF_B_COLUMNS)-1:0] m_col;
  logic                             m_row_last;

  modport master (output m_valid, m_data, m_last, m_row, m_col, m_row_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last, m_row, m_col, m_row_last, output m_ready);
`else
  modport master (output m_valid, m_data, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last, output m_ready);
`endif
endinterface

// File: rtl/matrix_result_serializer_index_counter.sv
// -----------------------------------------------------------------------------
// matrix_index_counter
// Row-major element index over a ROWS x COLS matrix, wrapping to 0 after the
// last element. Optional row/col counters advance in lock-step with idx.
// Ports:
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   load_zero_i     : restart at element 0 (has priority over advance)
//   advance_i       : step to the next element
//   idx_o, last_o   : current index, high when idx == ROWS*COLS-1
//   row_o, col_o, row_last_o : coordinates (MATRIX_SERIALIZER_COORD_EN only)
// -----------------------------------------------------------------------------
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter int ROWS = DEF_A_ROWS,
  parameter int COLS = DEF_B_COLUMNS
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          load_zero_i,
  input  logic                          advance_i,
  output logic [$clog2(ROWS*COLS)-1:0]  idx_o,
  output logic                          last_o
`ifdef MATRIX_SERIALIZER_COORD_EN
  ,
  output logic [$clog2(ROWS)-1:0]       row_o,
  output logic [$clog2(COLS)-1:0]       col_o,
  output logic                          row_last_o
`endif
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] r_idx;

  assign idx_o  = r_idx;
  assign last_o = (r_idx == IDX_W'(N - 1));

  // Linear element index with wrap after the final element.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_idx <= '0;
    end else if (load_zero_i) begin
      r_idx <= '0;
    end else if (advance_i) begin
      r_idx <= last_o ? '0 : (r_idx + IDX_W'(1));
    end
  end

`ifdef MATRIX_SERIALIZER_COORD_EN
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  assign row_o      = r_row;
  assign col_o      = r_col;
  assign row_last_o = (r_col == COL_W'(COLS - 1));

  // Row/column counters; the row wraps exactly when idx wraps.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_row <= '0;
      r_col <= '0;
    end else if (load_zero_i) begin
      r_row <= '0;
      r_col <= '0;
    end else if (advance_i) begin
      if (row_last_o) begin
        r_col <= '0;
        r_row <= (r_row == ROW_W'(ROWS - 1)) ? '0 : (r_row + ROW_W'(1));
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end
`endif

endmodule

// File: rtl/matrix_result_serializer.sv
// -----------------------------------------------------------------------------
// matrix_result_serializer
// Captures the multiplier's result matrix C on its one-cycle valid pulse and
// streams it out row-major, one element per beat, over a valid/ready stream.
// Results arriving mid-stream are dropped, flagged (sticky) and counted.
// Ports:
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   valid_i, c_i    : result pulse and row-major result array
//   m_if            : element stream (master modport)
//   busy_o          : a matrix is held and not fully sent
//   overflow_o      : sticky drop flag
//   drop_count_o    : saturating dropped-result count
//   clear_i         : synchronous clear of overflow_o / drop_count_o
// Optional feature macro: MATRIX_SERIALIZER_COORD_EN (row/col outputs on m_if).
// -----------------------------------------------------------------------------
module matrix_result_serializer
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int A_ROWS           = DEF_A_ROWS,
  parameter int B_COLUMNS        = DEF_B_COLUMNS,
  parameter int A_COLUMNS_B_ROWS = DEF_A_COLUMNS_B_ROWS,
  parameter int C_DATA_WIDTH     = c_data_width(DATA_WIDTH, A_COLUMNS_B_ROWS)
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    valid_i,
  input  logic [C_DATA_WIDTH-1:0] c_i [0:A_ROWS*B_COLUMNS-1],
  matrix_result_serializer_if.master m_if,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic [7:0]              drop_count_o,
  input  logic                    clear_i
);
  localparam int N     = A_ROWS * B_COLUMNS;
  localparam int IDX_W = $clog2(N);

  ser_state_e              r_state;
  logic [C_DATA_WIDTH-1:0] r_buf [0:N-1];
  logic                    r_overflow;
  logic [7:0]              r_drop_count;

  logic [IDX_W-1:0] w_idx;
  logic             w_idx_last;
  logic             w_stream;
  logic             w_accept;
  logic             w_last_accept;
  logic             w_capture;
  logic             w_drop;

  assign w_stream      = (r_state == STREAM);
  assign w_accept      = w_stream & m_if.m_ready;
  assign w_last_accept = w_accept & w_idx_last;
  // A new result is taken when idle, or in the very cycle the last beat leaves.
  assign w_capture     = valid_i & (~w_stream | w_last_accept);
  assign w_drop        = valid_i & w_stream & ~w_last_accept;

`ifdef MATRIX_SERIALIZER_COORD_EN
  logic [$clog2(A_ROWS)-1:0]    w_row;
  logic [$clog2(B_COLUMNS)-1:0] w_col;
  logic                         w_row_last;
`endif

  matrix_index_counter #(
    .ROWS (A_ROWS),
    .COLS (B_COLUMNS)
  ) u_index_counter (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .load_zero_i (w_capture),
    .advance_i   (w_accept),
    .idx_o       (w_idx),
    .last_o      (w_idx_last)
`ifdef MATRIX_SERIALIZER_COORD_EN
    ,
    .row_o       (w_row),
    .col_o       (w_col),
    .row_last_o  (w_row_last)
`endif
  );

  // Result buffer; contents are meaningless outside STREAM, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_capture) begin
      r_buf <= c_i;
    end
  end

  // Serializer state machine.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_capture) r_state <= STREAM;
        STREAM:  if (w_last_accept && !valid_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Drop flag and saturating counter; a drop outranks a same-cycle clear.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_overflow   <= 1'b0;
      r_drop_count <= 8'd0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      if (clear_i) begin
        r_drop_count <= 8'd1;
      end else if (r_drop_count != DROP_MAX) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end else if (clear_i) begin
      r_overflow   <= 1'b0;
      r_drop_count <= 8'd0;
    end
  end

  // Outputs derive from the state register and buffer only, never m_ready.
  assign m_if.m_valid = w_stream;
  assign m_if.m_data  = w_stream ? r_buf[w_idx] : '0;
  assign m_if.m_last  = w_stream & w_idx_last;
`ifdef MATRIX_SERIALIZER_COORD_EN
  assign m_if.m_row      = w_stream ? w_row : '0;
  assign m_if.m_col      = w_stream ? w_col : '0;
  assign m_if.m_row_last = w_stream & w_row_last;
`endif
  assign busy_o       = w_stream;
  assign overflow_o   = r_overflow;
  assign drop_count_o = r_drop_count;

endmodule

// File: tb/tb_matrix_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_matrix_result_serializer
// Directed + randomized bench for matrix_result_serializer. The reference model
// keeps the pending elements of the matrix in flight as a queue; drop flag and
// count are plain integers. Honours MATRIX_SERIALIZER_COORD_EN.
// -----------------------------------------------------------------------------
module tb_matrix_result_serializer;
  import matrix_pkg::*;

  localparam int N    = DEF_A_ROWS * DEF_B_COLUMNS;
  localparam int COLS = DEF_B_COLUMNS;
  localparam int CW   = DEF_C_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          reset_ni = 1'b0;
  logic          valid_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [CW-1:0] c_in [0:N-1];
  logic          busy;
  logic          ovf;
  logic [7:0]    dcnt;

  matrix_result_serializer_if #(.C_DATA_WIDTH(CW)) s_if();

  matrix_result_serializer dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .valid_i      (valid_i),
    .c_i          (c_in),
    .m_if         (s_if),
    .busy_o       (busy),
    .overflow_o   (ovf),
    .drop_count_o (dcnt),
    .clear_i      (clear_i)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_q[$];
  int            m_drops = 0;
  bit            m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = (exp_q.size() > 0);
    chk("m_valid", 32'(s_if.m_valid), 32'(v));
    chk("busy", 32'(busy), 32'(v));
    chk("m_data", 32'(s_if.m_data), v ? 32'(exp_q[0]) : 32'd0);
    chk("m_last", 32'(s_if.m_last), 32'(v && exp_q.size() == 1));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("drop_count", 32'(dcnt), 32'(m_drops));
`ifdef MATRIX_SERIALIZER_COORD_EN
    begin
      int pos;
      pos = N - exp_q.size();
      chk("m_row", 32'(s_if.m_row), v ? 32'(pos / COLS) : 32'd0);
      chk("m_col", 32'(s_if.m_col), v ? 32'(pos % COLS) : 32'd0);
      chk("m_row_last", 32'(s_if.m_row_last), 32'(v && (pos % COLS) == COLS - 1));
    end
`endif
  endtask

  // Apply one clock edge to the model using the inputs held across that edge.
  task automatic model_edge();
    bit had, acc, dropped;
    had = (exp_q.size() > 0);
    acc = had && s_if.m_ready;
    dropped = 1'b0;
    if (acc) void'(exp_q.pop_front());
    if (valid_i) begin
      if (!had || (acc && exp_q.size() == 0)) begin
        for (int i = 0; i < N; i++) exp_q.push_back(c_in[i]);
      end else begin
        dropped = 1'b1;
      end
    end
    if (dropped) begin
      m_ovf = 1'b1;
      m_drops = clear_i ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
    end else if (clear_i) begin
      m_ovf = 1'b0;
      m_drops = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic fill_seq(input int base);
    for (int i = 0; i < N; i++) c_in[i] = CW'(base + i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) c_in[i] = CW'($urandom);
  endtask

  task automatic pulse_result();
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    valid_i = 1'b0;
    clear_i = 1'b0;
    s_if.m_ready = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      step();
      k++;
    end
    step();
    @(negedge clk);
    chk("drain_idle", 32'(s_if.m_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    s_if.m_ready = 1'b0;
    fill_seq(1);

    // Reset state
    #3;
    chk("rst_valid", 32'(s_if.m_valid), 32'd0);
    chk("rst_data", 32'(s_if.m_data), 32'd0);
    chk("rst_last", 32'(s_if.m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_dcnt", 32'(dcnt), 32'd0);
    @(posedge clk);
    #1;
    reset_ni = 1'b1;
    step();
    step();

    // Basic stream: data 1..40, ready always high
    s_if.m_ready = 1'b1;
    fill_seq(1);
    pulse_result();
    drain(60);

    // Backpressure: ready pattern 1,0,0,1
    fill_rand();
    pulse_result();
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      s_if.m_ready = (k % 4 == 0) || (k % 4 == 3);
      step();
      k++;
    end
    drain(60);

    // Back-to-back: new result in the cycle the last beat is accepted
    fill_seq(1);
    pulse_result();
    k = 0;
    while (exp_q.size() > 1 && k < 60) begin
      step();
      k++;
    end
    fill_seq(100);
    pulse_result();
    drain(60);

    // Overflow: drop at beat 10, then 300 more while stalled, then clear
    fill_seq(1);
    pulse_result();
    repeat (9) step();
    fill_seq(500);
    pulse_result();
    s_if.m_ready = 1'b0;
    valid_i = 1'b1;
    repeat (300) step();
    valid_i = 1'b0;
    drain(60);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    step();

    // Clear and drop in the same cycle
    fill_rand();
    pulse_result();
    valid_i = 1'b1;
    clear_i = 1'b1;
    step();
    valid_i = 1'b0;
    clear_i = 1'b0;
    drain(60);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      valid_i = ($urandom_range(0, 19) == 0);
      s_if.m_ready = ($urandom_range(0, 3) != 0);
      clear_i = ($urandom_range(0, 49) == 0);
      if (valid_i) fill_rand();
      step();
    end
    drain(200);

    // Reset mid-stream at beat 20, asynchronously between edges
    fill_seq(1);
    pulse_result();
    repeat (19) step();
    #2;
    reset_ni = 1'b0;
    #1;
    exp_q.delete();
    m_drops = 0;
    m_ovf = 1'b0;
    chk("amid_valid", 32'(s_if.m_valid), 32'd0);
    chk("amid_busy", 32'(busy), 32'd0);
    chk("amid_last", 32'(s_if.m_last), 32'd0);
    chk("amid_data", 32'(s_if.m_data), 32'd0);
    chk("amid_dcnt", 32'(dcnt), 32'd0);
    @(posedge clk);
    #1;
    reset_ni = 1'b1;
    fill_seq(200);
    pulse_result();
    drain(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
